hid_report_packer: RTL
======================

Name: hid_report_packer

Overview:
- Downstream consumer of the pattern/motion source. Takes per-report signed deltas (`mouse_x`, `mouse_y`, `buttons`, `report_req` pulse) and accumulates them.
- Serialises them as USB HID boot-protocol mouse reports: byte-wide valid/ready stream into the interrupt-IN endpoint FIFO.
- Carries unsent motion across endpoint back-pressure. No movement is lost except by explicit saturation.

Parameters:
- REPORT_LEN, 3: bytes per report. Legal values 3 (boot) or 4 (appends wheel byte, always 0x00).
- ACC_LIMIT, 1023: magnitude clamp of the internal per-axis accumulator. Range ±ACC_LIMIT; must be ≥127 and fit in ACC_W.
- ACC_W, 12: signed accumulator width.
- SEND_IDLE, 0: when 1, every `report_req` yields a report even if there is no motion or button change.

Ports:
- clk  in  1  48 MHz system clock
- rst_n  in  1  reset, synchronous, active-low
- configured  in  1  USB device configured; low = flush and hold idle
- mouse_x  in  8  signed X delta (two's complement)
- mouse_y  in  8  signed Y delta
- buttons  in  3  {middle, right, left}
- report_req  in  1  single-cycle strobe: inputs valid this cycle
- tx_data  out  8  report byte
- tx_valid  out  1  `tx_data` valid
- tx_last  out  1  final byte of report
- tx_ready  in  1  endpoint FIFO accepts byte when `tx_valid` && `tx_ready`
- pkt_count  out  16  reports completed, wraps at 0xFFFF→0
- acc_sat  out  1  sticky: an accumulator clamped at ±ACC_LIMIT

Behaviour:
- Reset (`rst_n`=0 at an edge):
  - `tx_data`=0, `tx_valid`=0, `tx_last`=0, `pkt_count`=0, `acc_sat`=0.
  - Accumulators = 0; pending/sent button registers = 0; FSM = IDLE.
- Accumulation, on a sampled `report_req` (only while `configured`):
  - `acc` ← clamp(`acc` + sext(delta) − taken, ±ACC_LIMIT), per axis. "taken" is the value snapshotted this same cycle, else 0.
  - Any clamp sets `acc_sat`.
  - `pend_btn` ← `buttons`.
  - If SEND_IDLE=1, set `force_flag`.
- Pending condition: `acc_x`≠0 || `acc_y`≠0 || `pend_btn`≠`sent_btn` || `force_flag`.
- FSM states: IDLE, SEND_BTN, SEND_X, SEND_Y, SEND_W.
- IDLE, when pending:
  - Snapshot `out_x` = clamp(`acc_x`, −127..+127), same for `out_y`.
  - `acc` −= `out` (residual carried forward).
  - `sent_btn` ← `pend_btn`; clear `force_flag`.
  - Go to SEND_BTN with `tx_valid`=1, `tx_data`={5'b0, `pend_btn`}.
  - −128 is never emitted.
- Latency: `report_req` in cycle c → `tx_valid` high in cycle c+2 when FSM is IDLE.
- Byte sequence: SEND_BTN → SEND_X (`out_x`) → SEND_Y (`out_y`) → SEND_W (0x00, only if REPORT_LEN=4) → IDLE.
  - Advance only on `tx_valid` && `tx_ready`.
  - `tx_last`=1 exactly on the final byte.
- Handshake:
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data`/`tx_last` hold stable.
  - `tx_valid` never drops before acceptance, except on `configured`=0 or reset.
- Completion: on acceptance of the last byte, `pkt_count`++ and return to IDLE.
  - If still pending, the next report starts the following cycle (one idle cycle between reports, `tx_valid`=0).
- Mid-report arrivals: `report_req` during SEND_* accumulates normally into the residual and is reflected in the next report. The snapshot is never modified mid-report.
- `configured`=0 (any state):
  - Next edge: FSM→IDLE, `tx_valid`=0, `tx_last`=0.
  - Accumulators, `pend_btn`, `sent_btn` and `force_flag` are cleared; `acc_sat` is cleared.
  - `report_req` is ignored.
  - A partial report is abandoned (the FIFO is flushed by the USB core).
  - `pkt_count` is retained.
- Width rules:
  - Deltas are sign-extended to ACC_W.
  - Sums are computed at ACC_W+2 bits before clamp.
  - Output bytes are the two's-complement low 8 bits of the clamped value.

Decomposition:
- Package `hid_mouse_pkg` holds:
  - enum `report_state_t` {IDLE, SEND_BTN, SEND_X, SEND_Y, SEND_W};
  - localparams BOOT_REPORT_LEN=3, HID_DELTA_MAX=127, HID_DELTA_MIN=−127;
  - function `clamp_delta`.
- One sub-module `sat_axis_accum`, instantiated twice (X, Y). Responsibilities:
  - signed add and subtract-taken;
  - ±ACC_LIMIT clamp with saturation flag;
  - snapshot output clamped to ±127.

Test Plan:
- Single move: `report_req` with x=+5, y=−3, buttons=3'b001, `tx_ready`=1 → bytes 0x01, 0x05, 0xFD; `tx_last` on byte 3; `tx_valid` first high at c+2; `pkt_count`=1.
- Back-pressure: `tx_ready`=0 for 20 cycles during SEND_X; five `report_req` with x=+10 meanwhile → X byte is held stable; next report carries X=0x32 (50).
- Large residual: three `report_req` x=+100 with `tx_ready`=0 before first acceptance → reports X=+100 then +127 then +73; `acc_x` ends 0.
- Saturation: 20 `report_req` x=−128 under stall (−2560, clamp at −1023) → `acc_sat`=1; drained reports total exactly −1023 (−127×8, −7).
- No-change suppression: `report_req` x=0, y=0, same buttons, SEND_IDLE=0 → no `tx_valid`; with SEND_IDLE=1 → report 0x00, 0x00, 0x00; button-only change 0→3'b100 → report 0x04, 0x00, 0x00.
- Abort: `configured` drops during SEND_Y → next cycle `tx_valid`=0, state IDLE, `acc_sat`=0, `pkt_count` unchanged; after re-enable, first report reflects only post-enable deltas; REPORT_LEN=4 variant shows 4th byte 0x00 with `tx_last`.

Source files
------------

// File: rtl/hid_mouse_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hid_mouse_pkg
//  Purpose  : Shared types, constants and helpers for the HID boot-protocol
//             mouse report packer.
//  Contents : report_state_t  - report serialiser FSM states
//             BOOT_REPORT_LEN - bytes in a boot-protocol mouse report
//             HID_DELTA_MAX/MIN - legal per-report delta range (+/-127)
//             clamp_delta()   - clamp a signed value into a report byte
//  Revision : 1.0 - initial release
// ============================================================================
package hid_mouse_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_BTN = 3'd1,
        SEND_X   = 3'd2,
        SEND_Y   = 3'd3,
        SEND_W   = 3'd4
    } report_state_t;

    localparam int BOOT_REPORT_LEN = 3;
    localparam int HID_DELTA_MAX   = 127;
    localparam int HID_DELTA_MIN   = -127;

    // -128 is deliberately excluded: the lower bound is symmetric with +127.
    function automatic logic [7:0] clamp_delta(input logic signed [31:0] value);
        logic [7:0] result;
        if (value > HID_DELTA_MAX) begin
            result = 8'(HID_DELTA_MAX);
        end else if (value < HID_DELTA_MIN) begin
            result = 8'(HID_DELTA_MIN);
        end else begin
            result = value[7:0];
        end
        return result;
    endfunction

endpackage : hid_mouse_pkg
`default_nettype wire

// File: rtl/sat_axis_accum.sv
`default_nettype none
// ============================================================================
//  Module   : sat_axis_accum
//  Purpose  : One motion axis accumulator. Adds incoming 8-bit signed deltas,
//             subtracts the amount handed to the current report, and clamps
//             the running total to +/-ACC_LIMIT.
//  Ports    : clk, rst_n     - clock, synchronous active-low reset
//             i_clear        - synchronous flush of the accumulator
//             i_add_en       - add i_delta this cycle
//             i_delta        - signed delta (two's complement)
//             i_take_en      - the current snapshot is consumed this cycle
//             o_snap         - accumulator clamped to +/-127 (report byte)
//             o_nonzero      - accumulator holds unsent motion
//             o_sat          - the update this cycle was clamped
//  Revision : 1.0 - initial release
// ============================================================================
module sat_axis_accum
    import hid_mouse_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int ACC_LIMIT = 1023
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_add_en,
    input  logic [7:0] i_delta,
    input  logic       i_take_en,
    output logic [7:0] o_snap,
    output logic       o_nonzero,
    output logic       o_sat
);

    // Two guard bits so acc + delta - taken can never wrap before the clamp.
    localparam int c_sum_w = ACC_W + 2;
    localparam logic signed [c_sum_w-1:0] c_lim_pos = c_sum_w'(ACC_LIMIT);
    localparam logic signed [c_sum_w-1:0] c_lim_neg = -c_lim_pos;

    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [c_sum_w-1:0] w_add_term;
    logic signed [c_sum_w-1:0] w_take_term;
    logic signed [c_sum_w-1:0] w_sum;

    assign o_snap    = clamp_delta(32'(acc_q));
    assign o_nonzero = (acc_q != '0);

    always_comb begin
        w_add_term  = i_add_en  ? c_sum_w'(signed'(i_delta)) : '0;
        w_take_term = i_take_en ? c_sum_w'(signed'(o_snap))  : '0;
        w_sum       = c_sum_w'(acc_q) + w_add_term - w_take_term;
        acc_d       = acc_q;
        o_sat       = 1'b0;
        if (i_clear) begin
            acc_d = '0;
        end else if (w_sum > c_lim_pos) begin
            acc_d = ACC_W'(c_lim_pos);
            o_sat = 1'b1;
        end else if (w_sum < c_lim_neg) begin
            acc_d = ACC_W'(c_lim_neg);
            o_sat = 1'b1;
        end else begin
            acc_d = w_sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : sat_axis_accum
`default_nettype wire

// File: rtl/hid_report_packer.sv
`default_nettype none
// ============================================================================
//  Module   : hid_report_packer
//  Purpose  : Accumulates per-report mouse deltas and button state and
//             serialises them as USB HID boot-protocol mouse reports onto a
//             byte-wide valid/ready stream. Motion not yet sent survives
//             endpoint back-pressure; only explicit saturation loses it.
//  Ports    : clk, rst_n     - 48 MHz clock, synchronous active-low reset
//             configured     - device configured; low flushes and idles
//             mouse_x/y      - signed deltas, buttons {mid,right,left}
//             report_req     - strobe: deltas/buttons valid this cycle
//             tx_data/valid/last, tx_ready - report byte stream
//             pkt_count      - completed reports (wrapping)
//             acc_sat        - sticky accumulator clamp indicator
//  Revision : 1.0 - initial release
// ============================================================================
module hid_report_packer
    import hid_mouse_pkg::*;
#(
    parameter int REPORT_LEN = 3,
    parameter int ACC_LIMIT  = 1023,
    parameter int ACC_W      = 12,
    parameter int SEND_IDLE  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        configured,
    input  logic [7:0]  mouse_x,
    input  logic [7:0]  mouse_y,
    input  logic [2:0]  buttons,
    input  logic        report_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_last,
    input  logic        tx_ready,
    output logic [15:0] pkt_count,
    output logic        acc_sat
);

    localparam bit c_has_wheel = (REPORT_LEN != BOOT_REPORT_LEN);

    report_state_t state_q, state_d;
    logic [7:0]  tx_data_q,   tx_data_d;
    logic        tx_valid_q,  tx_valid_d;
    logic        tx_last_q,   tx_last_d;
    logic [15:0] pkt_count_q, pkt_count_d;
    logic        acc_sat_q,   acc_sat_d;
    logic [2:0]  pend_btn_q,  pend_btn_d;
    logic [2:0]  sent_btn_q,  sent_btn_d;
    logic        force_q,     force_d;
    logic [7:0]  out_x_q,     out_x_d;
    logic [7:0]  out_y_q,     out_y_d;

    logic       w_add_en;
    logic       w_take;
    logic       w_pending;
    logic       w_accept;
    logic [7:0] w_snap_x;
    logic [7:0] w_snap_y;
    logic       w_nz_x;
    logic       w_nz_y;
    logic       w_sat_x;
    logic       w_sat_y;

    assign w_add_en  = report_req && configured;
    assign w_accept  = tx_valid_q && tx_ready;
    assign w_pending = w_nz_x || w_nz_y || (pend_btn_q != sent_btn_q) || force_q;
    // Snapshot happens on the IDLE cycle that launches a report.
    assign w_take    = configured && (state_q == IDLE) && w_pending;

    sat_axis_accum #(
        .ACC_W     (ACC_W),
        .ACC_LIMIT (ACC_LIMIT)
    ) u_acc_x (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (!configured),
        .i_add_en  (w_add_en),
        .i_delta   (mouse_x),
        .i_take_en (w_take),
        .o_snap    (w_snap_x),
        .o_nonzero (w_nz_x),
        .o_sat     (w_sat_x)
    );

    sat_axis_accum #(
        .ACC_W     (ACC_W),
        .ACC_LIMIT (ACC_LIMIT)
    ) u_acc_y (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (!configured),
        .i_add_en  (w_add_en),
        .i_delta   (mouse_y),
        .i_take_en (w_take),
        .o_snap    (w_snap_y),
        .o_nonzero (w_nz_y),
        .o_sat     (w_sat_y)
    );

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        tx_last_d   = tx_last_q;
        pkt_count_d = pkt_count_q;
        acc_sat_d   = acc_sat_q;
        pend_btn_d  = pend_btn_q;
        sent_btn_d  = sent_btn_q;
        force_d     = force_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;

        if (!configured) begin
            // Abandon any partial report; the USB core flushes its FIFO.
            state_d    = IDLE;
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            pend_btn_d = '0;
            sent_btn_d = '0;
            force_d    = 1'b0;
            acc_sat_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (w_pending) begin
                        out_x_d    = w_snap_x;
                        out_y_d    = w_snap_y;
                        sent_btn_d = pend_btn_q;
                        force_d    = 1'b0;
                        state_d    = SEND_BTN;
                        tx_valid_d = 1'b1;
                        tx_data_d  = {5'b0, pend_btn_q};
                        tx_last_d  = 1'b0;
                    end
                end
                SEND_BTN: begin
                    if (w_accept) begin
                        state_d   = SEND_X;
                        tx_data_d = out_x_q;
                    end
                end
                SEND_X: begin
                    if (w_accept) begin
                        state_d   = SEND_Y;
                        tx_data_d = out_y_q;
                        tx_last_d = !c_has_wheel;
                    end
                end
                SEND_Y: begin
                    if (w_accept) begin
                        if (c_has_wheel) begin
                            state_d   = SEND_W;
                            tx_data_d = 8'h00;
                            tx_last_d = 1'b1;
                        end else begin
                            state_d     = IDLE;
                            tx_valid_d  = 1'b0;
                            tx_last_d   = 1'b0;
                            pkt_count_d = pkt_count_q + 16'd1;
                        end
                    end
                end
                SEND_W: begin
                    if (w_accept) begin
                        state_d     = IDLE;
                        tx_valid_d  = 1'b0;
                        tx_last_d   = 1'b0;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                end
                default: begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    tx_last_d  = 1'b0;
                end
            endcase

            // Applied after the snapshot so a request landing on the launch
            // cycle still forces a follow-up report.
            if (w_add_en) begin
                pend_btn_d = buttons;
                if (SEND_IDLE != 0) begin
                    force_d = 1'b1;
                end
            end
            acc_sat_d = acc_sat_q || w_sat_x || w_sat_y;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            pkt_count_q <= '0;
            acc_sat_q   <= 1'b0;
            pend_btn_q  <= '0;
            sent_btn_q  <= '0;
            force_q     <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            pkt_count_q <= pkt_count_d;
            acc_sat_q   <= acc_sat_d;
            pend_btn_q  <= pend_btn_d;
            sent_btn_q  <= sent_btn_d;
            force_q     <= force_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign tx_last   = tx_last_q;
    assign pkt_count = pkt_count_q;
    assign acc_sat   = acc_sat_q;

endmodule : hid_report_packer
`default_nettype wire
